// File: rtl/i2s_pkg.sv
// Shared types and defaults for the stereo I2S receiver.
// Optional frame checking is enabled with the I2S_RX_FRAME_CHECK_EN macro.
package i2s_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_LEFT   = 2'd1,
        ST_RIGHT  = 2'd2,
        ST_IGNORE = 2'd3
    } rx_state_e;

    localparam int DATA_W_DEF      = 24;
    localparam int SLOT_W_DEF      = 32;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int ERR_CNT_W       = 16;

endpackage

// File: rtl/i2s_sync_edge.sv
// Brings bck/lrck/data_in into the mck domain and produces a one-mck strobe per bck rise,
// with lrck/data delayed to match so they are sampled at the same instant as bck.
module i2s_sync_edge
    import i2s_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic mck,
    input  logic rst_n,
    input  logic bck,
    input  logic lrck,
    input  logic data_in,
    output logic bck_rise,
    output logic lrck_s,
    output logic data_s
);

    logic [SYNC_STAGES-1:0] bck_sync_q, bck_sync_d;
    logic                   bck_prev_q, bck_prev_d;
    logic                   bck_rise_q, bck_rise_d;
    // One extra stage on lrck/data matches the edge-detect flop on bck.
    logic [SYNC_STAGES:0]   lrck_pipe_q, lrck_pipe_d;
    logic [SYNC_STAGES:0]   data_pipe_q, data_pipe_d;

    always_comb begin
        bck_sync_d  = {bck_sync_q[SYNC_STAGES-2:0], bck};
        bck_prev_d  = bck_sync_q[SYNC_STAGES-1];
        bck_rise_d  = bck_sync_q[SYNC_STAGES-1] & ~bck_prev_q;
        lrck_pipe_d = {lrck_pipe_q[SYNC_STAGES-1:0], lrck};
        data_pipe_d = {data_pipe_q[SYNC_STAGES-1:0], data_in};
    end

    // NOTE: sequential state uses <= so every flop samples the pre-edge values.
    always_ff @(posedge mck or negedge rst_n) begin
        if (!rst_n) begin
            bck_sync_q  <= '0;
            bck_prev_q  <= 1'b0;
            bck_rise_q  <= 1'b0;
            lrck_pipe_q <= '0;
            data_pipe_q <= '0;
        end else begin
            bck_sync_q  <= bck_sync_d;
            bck_prev_q  <= bck_prev_d;
            bck_rise_q  <= bck_rise_d;
            lrck_pipe_q <= lrck_pipe_d;
            data_pipe_q <= data_pipe_d;
        end
    end

    assign bck_rise = bck_rise_q;
    assign lrck_s   = lrck_pipe_q[SYNC_STAGES];
    assign data_s   = data_pipe_q[SYNC_STAGES];

endmodule

// File: rtl/i2s_rx_stereo.sv
// Stereo I2S receiver: frames left/right slots on lrck edges and hands out sample pairs
// over valid/ready. Define I2S_RX_FRAME_CHECK_EN to add frame_err / err_count outputs.
module i2s_rx_stereo
    import i2s_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SLOT_W      = SLOT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              mck,
    input  logic              reset_n,
    input  logic              bck,
    input  logic              lrck,
    input  logic              data_in,
    output logic [DATA_W-1:0] out_left,
    output logic [DATA_W-1:0] out_right,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun
`ifdef I2S_RX_FRAME_CHECK_EN
    ,
    output logic                 frame_err,
    output logic [ERR_CNT_W-1:0] err_count
`endif
);

    localparam int                CNT_W      = $clog2(SLOT_W + 1);
    localparam logic [CNT_W-1:0]  DATA_W_C   = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_BIT_C = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  SLOT_W_C   = CNT_W'(SLOT_W);

    // Assert asynchronously, release on an mck edge so no flop sees a metastable release.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge mck or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_n = rst_sync_q[1];

    logic bck_rise, lrck_s, data_s;

    i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .mck      (mck),
        .rst_n    (rst_n),
        .bck      (bck),
        .lrck     (lrck),
        .data_in  (data_in),
        .bck_rise (bck_rise),
        .lrck_s   (lrck_s),
        .data_s   (data_s)
    );

    rx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              lrck_prev_q, lrck_prev_d;
    logic [DATA_W-1:0] left_q, left_d;
    logic [DATA_W-1:0] right_q, right_d;
    logic [DATA_W-1:0] out_left_q, out_left_d;
    logic [DATA_W-1:0] out_right_q, out_right_d;
    logic              out_valid_q, out_valid_d;
    logic              overrun_q, overrun_d;
    logic              lr_edge;
    logic              pair_done;
    logic              slot_err;

    // NOTE: every signal gets a default first so this block cannot infer a latch.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        lrck_prev_d = lrck_prev_q;
        left_d      = left_q;
        right_d     = right_q;
        lr_edge     = lrck_s != lrck_prev_q;
        pair_done   = 1'b0;
        slot_err    = 1'b0;

        if (bck_rise) begin
            lrck_prev_d = lrck_s;
            case (state_q)
                ST_HUNT: begin
                    if (lr_edge && !lrck_s) begin
                        state_d   = ST_LEFT;
                        bit_cnt_d = '0;
                    end
                end
                ST_LEFT, ST_RIGHT: begin
                    if (lr_edge) begin
                        if (bit_cnt_q >= DATA_W_C) begin
                            state_d   = (state_q == ST_LEFT) ? ST_RIGHT : ST_LEFT;
                            bit_cnt_d = '0;
                        end else begin
                            state_d  = ST_HUNT;
                            slot_err = 1'b1;
                        end
                    end else begin
                        // The edge strobe carries the previous slot's LSB, so shifting starts one strobe later.
                        if (bit_cnt_q < DATA_W_C) begin
                            if (state_q == ST_LEFT) begin
                                left_d = {left_q[DATA_W-2:0], data_s};
                            end else begin
                                right_d   = {right_q[DATA_W-2:0], data_s};
                                pair_done = (bit_cnt_q == LAST_BIT_C);
                            end
                        end
                        if (bit_cnt_q < SLOT_W_C) bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_d == SLOT_W_C) begin
                            state_d  = ST_IGNORE;
                            slot_err = 1'b1;
                        end
                    end
                end
                ST_IGNORE: state_d = ST_HUNT;
                default:   state_d = ST_HUNT;
            endcase
        end
    end

    always_comb begin
        out_left_d  = out_left_q;
        out_right_d = out_right_q;
        out_valid_d = out_valid_q;
        overrun_d   = 1'b0;

        if (pair_done) begin
            if (!out_valid_q || out_ready) begin
                out_left_d  = left_q;
                out_right_d = right_d;
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge mck or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HUNT;
            bit_cnt_q   <= '0;
            lrck_prev_q <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
            out_left_q  <= '0;
            out_right_q <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            lrck_prev_q <= lrck_prev_d;
            left_q      <= left_d;
            right_q     <= right_d;
            out_left_q  <= out_left_d;
            out_right_q <= out_right_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_left  = out_left_q;
    assign out_right = out_right_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

`ifdef I2S_RX_FRAME_CHECK_EN
    logic                 frame_err_q, frame_err_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    always_comb begin
        frame_err_d = slot_err;
        err_count_d = err_count_q;
        if (slot_err && (err_count_q != '1)) err_count_d = err_count_q + ERR_CNT_W'(1);
    end

    always_ff @(posedge mck or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            frame_err_q <= frame_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign frame_err = frame_err_q;
    assign err_count = err_count_q;
`else
    logic unused_slot_err;
    assign unused_slot_err = slot_err;
`endif

endmodule

// File: tb/tb_i2s_rx_stereo.sv
// Directed bench for i2s_rx_stereo: drives I2S frames at mck = 16x bck, 64 bck/frame,
// and scores every delivered pair against a queue of expected pairs.
module tb_i2s_rx_stereo;

    localparam int DATA_W = 24;
    localparam int SLOT_W = 32;
    localparam int HALF   = 32;

    typedef struct {
        logic [DATA_W-1:0] l;
        logic [DATA_W-1:0] r;
    } pair_t;

    logic              mck       = 1'b0;
    logic              reset_n   = 1'b0;
    logic              bck       = 1'b0;
    logic              lrck      = 1'b1;
    logic              data_in   = 1'b0;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_left, out_right;
    logic              out_valid, overrun;
`ifdef I2S_RX_FRAME_CHECK_EN
    logic              frame_err;
    logic [15:0]       err_count;
`endif

    i2s_rx_stereo #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .SYNC_STAGES(2)) dut (
        .mck       (mck),
        .reset_n   (reset_n),
        .bck       (bck),
        .lrck      (lrck),
        .data_in   (data_in),
        .out_left  (out_left),
        .out_right (out_right),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
`ifdef I2S_RX_FRAME_CHECK_EN
        ,
        .frame_err (frame_err),
        .err_count (err_count)
`endif
    );

    always #5 mck = ~mck;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: pairs the transmitter sent as complete, aligned frames that the consumer must see.
    pair_t             exp_q[$];
    int                valid_cycles  = 0;
    int                overrun_count = 0;
    int                pairs_seen    = 0;
    int                err_pulses    = 0;
    logic              held          = 1'b0;
    logic              overrun_prev  = 1'b0;
    logic [DATA_W-1:0] held_l, held_r, last_l, last_r;

    always @(negedge mck) begin
        if (!reset_n) begin
            held         = 1'b0;
            overrun_prev = 1'b0;
        end else begin
            if (out_valid) valid_cycles++;
            if (overrun) overrun_count++;
`ifdef I2S_RX_FRAME_CHECK_EN
            if (frame_err) err_pulses++;
`endif
            if (overrun_prev) check("overrun_one_cycle", 32'(overrun), 32'd0);
            if (held) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_left", 32'(out_left), 32'(held_l));
                check("hold_right", 32'(out_right), 32'(held_r));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pair: got L=%0h R=%0h expected none", out_left, out_right);
                end else begin
                    pair_t p;
                    p = exp_q.pop_front();
                    check("pair_left", 32'(out_left), 32'(p.l));
                    check("pair_right", 32'(out_right), 32'(p.r));
                end
                pairs_seen++;
                last_l = out_left;
                last_r = out_right;
            end
            held         = out_valid && !out_ready;
            held_l       = out_left;
            held_r       = out_right;
            overrun_prev = overrun;
        end
    end

    logic prev_bit = 1'b0;

    task automatic bck_cycle(input logic lr, input logic d);
        bck     = 1'b0;
        lrck    = lr;
        data_in = d;
        repeat (8) @(posedge mck);
        #1;
        bck = 1'b1;
        repeat (8) @(posedge mck);
        #1;
    endtask

    // First bit of a slot carries the previous slot's last bit (I2S one-bit delay).
    task automatic send_slot(input logic lr, input logic [DATA_W-1:0] w, input int nbits,
                             input int slot_len, input logic pad);
        logic b;
        bck_cycle(lr, prev_bit);
        for (int i = 0; i < slot_len - 1; i++) begin
            b = (i < nbits) ? w[DATA_W-1-i] : pad;
            bck_cycle(lr, b);
            prev_bit = b;
        end
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                              input logic pad, input logic deliver);
        pair_t p;
        p.l = l;
        p.r = r;
        if (deliver) exp_q.push_back(p);
        send_slot(1'b0, l, DATA_W, HALF, pad);
        send_slot(1'b1, r, DATA_W, HALF, pad);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    int v0, o0, p0, e0;

    initial begin
        repeat (5) @(posedge mck);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_left", 32'(out_left), 32'd0);
        check("rst_right", 32'(out_right), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        reset_n = 1'b1;
        repeat (4) @(posedge mck);
        #1;
        for (int i = 0; i < 4; i++) bck_cycle(1'b1, 1'b0);

        // Nominal frame, consumer always ready.
        v0 = valid_cycles;
        o0 = overrun_count;
        send_frame(24'h123456, 24'hABCDEF, 1'b0, 1'b1);
        check("nom_valid_cycles", 32'(valid_cycles - v0), 32'd1);
        check("nom_overrun", 32'(overrun_count - o0), 32'd0);
        check("nom_left_lit", 32'(last_l), 32'h123456);
        check("nom_right_lit", 32'(last_r), 32'hABCDEF);

        // Extremes with padding = 1; the following frame has a 1 in its left delay bit.
        send_frame(24'h800000, 24'h7FFFFF, 1'b1, 1'b1);
        check("sign_left_lit", 32'(last_l), 32'h800000);
        check("sign_right_lit", 32'(last_r), 32'h7FFFFF);
        send_frame(24'h3C3C3C, 24'hC3C3C3, 1'b1, 1'b1);
        check("delay_left_lit", 32'(last_l), 32'h3C3C3C);

        // Backpressure: A held, B dropped with one overrun, then C after release.
        out_ready = 1'b0;
        o0 = overrun_count;
        p0 = pairs_seen;
        send_frame(24'hA1B2C3, 24'h0F1E2D, 1'b0, 1'b1);
        send_frame(24'h55AA55, 24'hAA55AA, 1'b0, 1'b0);
        check("bp_overrun", 32'(overrun_count - o0), 32'd1);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_left", 32'(out_left), 32'hA1B2C3);
        check("bp_right", 32'(out_right), 32'h0F1E2D);
        check("bp_none_taken", 32'(pairs_seen - p0), 32'd0);
        out_ready = 1'b1;
        repeat (4) @(posedge mck);
        #1;
        check("bp_accepted", 32'(pairs_seen - p0), 32'd1);
        check("bp_valid_clr", 32'(out_valid), 32'd0);
        send_frame(24'h13579B, 24'h2468AC, 1'b0, 1'b1);
        check("bp_next", 32'(pairs_seen - p0), 32'd2);
        check("bp_next_lit", 32'(last_r), 32'h2468AC);

        // Short left slot (20 bits) discards the frame; the next frame recovers.
        p0 = pairs_seen;
        e0 = err_pulses;
        send_slot(1'b0, 24'hFEDCBA, 20, 21, 1'b0);
        send_slot(1'b1, 24'h654321, DATA_W, HALF, 1'b0);
        check("short_no_pair", 32'(pairs_seen - p0), 32'd0);
`ifdef I2S_RX_FRAME_CHECK_EN
        check("short_frame_err", 32'(err_pulses - e0), 32'd1);
        check("short_err_count", 32'(err_count), 32'd1);
`endif
        send_frame(24'h0A0B0C, 24'hF0E0D0, 1'b0, 1'b1);
        check("short_recover", 32'(pairs_seen - p0), 32'd1);
        check("short_recover_lit", 32'(last_l), 32'h0A0B0C);

        // Reset at bit 10 of the right slot; restart mid-right with lrck high.
        p0 = pairs_seen;
        send_slot(1'b0, 24'h777777, DATA_W, HALF, 1'b0);
        send_slot(1'b1, 24'h888888, 10, 11, 1'b0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_left", 32'(out_left), 32'd0);
        check("mid_rst_right", 32'(out_right), 32'd0);
        check("mid_rst_overrun", 32'(overrun), 32'd0);
`ifdef I2S_RX_FRAME_CHECK_EN
        check("mid_rst_err_count", 32'(err_count), 32'd0);
`endif
        repeat (3) @(posedge mck);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 21; i++) bck_cycle(1'b1, 1'b1);
        prev_bit = 1'b1;
        check("startup_no_pair", 32'(pairs_seen - p0), 32'd0);
        send_frame(24'h400001, 24'hBFFFFE, 1'b0, 1'b1);
        check("startup_first", 32'(pairs_seen - p0), 32'd1);
        check("startup_left_lit", 32'(last_l), 32'h400001);
        check("startup_right_lit", 32'(last_r), 32'hBFFFFE);

        repeat (20) @(posedge mck);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
